// File: rtl/spart_pkg.sv
// ---------------------------------------------------------------------------
// spart_pkg
// Shared definitions for the SPART receive path: processor register
// addresses, status-byte bit positions and the receive capture-state enum.
// ---------------------------------------------------------------------------
package spart_pkg;

  // Processor register map
  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;

  // Status byte layout: [7] overrun, [6] 0, [5] full, [4] empty, [3:0] level
  localparam int STAT_OVERRUN = 7;
  localparam int STAT_FULL    = 5;
  localparam int STAT_EMPTY   = 4;
  localparam int STAT_LVL_MSB = 3;

  // Receive capture handshake states
  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_ACK  = 1'b1
  } cap_state_t;

endpackage

// File: rtl/spart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// spart_rx_fifo_if
// Groups the receiver handshake and processor bus of spart_rx_fifo.
//   master : the environment (receiver + processor) driving the FIFO
//   slave  : the FIFO itself
// ---------------------------------------------------------------------------
interface spart_rx_fifo_if;

  logic       i_rda;      // receiver data available (sticky level)
  logic [7:0] i_rx_data;  // receiver byte, valid while i_rda is high
  logic       o_rx_ack;   // acknowledge back to the receiver
  logic       i_iocs;     // processor chip select
  logic       i_iorw;     // processor direction, 1 = read
  logic [1:0] i_ioaddr;   // register address
  logic [7:0] o_rdata;    // processor read data
  logic       o_rda;      // FIFO non-empty

  modport master (
    output i_rda, i_rx_data, i_iocs, i_iorw, i_ioaddr,
    input  o_rx_ack, o_rdata, o_rda
  );

  modport slave (
    input  i_rda, i_rx_data, i_iocs, i_iorw, i_ioaddr,
    output o_rx_ack, o_rdata, o_rda
  );

endinterface

// File: rtl/spart_fifo_ram.sv
// ---------------------------------------------------------------------------
// spart_fifo_ram
// DEPTH x 8 storage for the receive FIFO. Synchronous write, asynchronous
// read, no reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
// ---------------------------------------------------------------------------
module spart_fifo_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array has no reset; entries are only read after being written,
  // so a reset would add logic without changing observable behaviour.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spart_rx_fifo.sv
// ---------------------------------------------------------------------------
// spart_rx_fifo
// Receive FIFO between the SPART receiver and the processor bus. Captures one
// byte per i_rda assertion, acknowledges the receiver, and exposes a data
// register (first-word fall-through, pop on read) and a status register
// (clear overrun on read).
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   i_rda     : receiver data available (sticky until acknowledged)
//   i_rx_data : receiver byte
//   o_rx_ack  : registered acknowledge, high for every CAP_ACK cycle
//   i_iocs    : processor chip select
//   i_iorw    : processor direction, 1 = read
//   i_ioaddr  : register address (00 data, 01 status, 1x reads zero)
//   o_rdata   : combinational read data for the current address
//   o_rda     : FIFO non-empty
// ---------------------------------------------------------------------------
module spart_rx_fifo
  import spart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rda,
  input  logic [7:0] i_rx_data,
  output logic       o_rx_ack,
  input  logic       i_iocs,
  input  logic       i_iorw,
  input  logic [1:0] i_ioaddr,
  output logic [7:0] o_rdata,
  output logic       o_rda
);

  localparam int PW = $clog2(DEPTH);

  cap_state_t    state_q, state_d;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   level;
  logic          overrun;
  logic          strobe_q;
  logic [7:0]    head;
  logic [7:0]    status;

  logic strobe, strobe_rise, push, pop, full, empty, do_write, ovr_set, ovr_clr;

  // ---------------- capture state machine ----------------
  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      CAP_IDLE: if (i_rda) begin
        state_d = CAP_ACK;
        push    = 1'b1;
      end
      CAP_ACK:  if (!i_rda) state_d = CAP_IDLE;
      default:  state_d = CAP_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= CAP_IDLE;
      o_rx_ack <= 1'b0;
    end else begin
      state_q  <= state_d;
      o_rx_ack <= (state_d == CAP_ACK);
    end
  end

  // ---------------- processor strobe ----------------
  assign strobe      = i_iocs & i_iorw;
  assign strobe_rise = strobe & ~strobe_q;

  // ---------------- FIFO control ----------------
  assign empty    = (level == '0);
  assign full     = (level == (PW+1)'(DEPTH));
  assign pop      = strobe_rise && (i_ioaddr == ADDR_DATA) && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_write = push && (!full || pop);
  assign ovr_set  = push && full && !pop;
  assign ovr_clr  = strobe_rise && (i_ioaddr == ADDR_STATUS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overrun  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= strobe;
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_write, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // Set wins over a coincident clearing status read.
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  spart_fifo_ram #(.DEPTH(DEPTH), .AW(PW)) u_ram (
    .clk   (clk),
    .we    (do_write),
    .waddr (wr_ptr),
    .wdata (i_rx_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // ---------------- read mux ----------------
  // Level field is four bits wide; at DEPTH=16 a full FIFO reads level 0
  // and is distinguished by the full bit.
  always_comb begin
    status                          = 8'h00;
    status[STAT_OVERRUN]            = overrun;
    status[STAT_FULL]               = full;
    status[STAT_EMPTY]              = empty;
    status[STAT_LVL_MSB:0]          = 4'(level);
  end

  always_comb begin
    o_rdata = 8'h00;
    unique case (i_ioaddr)
      ADDR_DATA:   o_rdata = empty ? 8'h00 : head;
      ADDR_STATUS: o_rdata = status;
      default:     o_rdata = 8'h00;
    endcase
  end

  assign o_rda = !empty;

endmodule

// File: tb/tb_spart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_spart_rx_fifo
// Directed and randomized bench for spart_rx_fifo (DEPTH = 8). A queue-based
// model tracks the FIFO contents, overrun flag, capture status and previous
// strobe; every comparison is an immediate assertion.
// ---------------------------------------------------------------------------
module tb_spart_rx_fifo;
  import spart_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spart_rx_fifo_if bus ();

  spart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_rda     (bus.i_rda),
    .i_rx_data (bus.i_rx_data),
    .o_rx_ack  (bus.o_rx_ack),
    .i_iocs    (bus.i_iocs),
    .i_iorw    (bus.i_iorw),
    .i_ioaddr  (bus.i_ioaddr),
    .o_rdata   (bus.o_rdata),
    .o_rda     (bus.o_rda)
  );

  // ---------------- reference model ----------------
  logic [7:0] m_q [$];
  bit         m_ovr;
  bit         m_busy;      // byte already taken for the current i_rda assertion
  bit         m_strobe_q;

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [7:0] exp_status();
    logic [7:0] s;
    s = {m_ovr, 1'b0, (m_q.size() == DEPTH), (m_q.size() == 0), 4'(m_q.size())};
    return s;
  endfunction

  function automatic logic [7:0] exp_rdata(input logic [1:0] a);
    if (a == ADDR_DATA)   return (m_q.size() != 0) ? m_q[0] : 8'h00;
    if (a == ADDR_STATUS) return exp_status();
    return 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    #1;
    chk({tag, "_rdata"}, bus.o_rdata, exp_rdata(bus.i_ioaddr));
    chk({tag, "_rda"}, {7'd0, bus.o_rda}, {7'd0, (m_q.size() != 0)});
    chk({tag, "_ack"}, {7'd0, bus.o_rx_ack}, {7'd0, m_busy});
  endtask

  // Apply one rising edge with the current inputs, updating the model first.
  task automatic tick();
    bit strobe, rise, set_ovr;
    strobe  = bus.i_iocs & bus.i_iorw;
    rise    = strobe && !m_strobe_q;
    set_ovr = 1'b0;
    if (rise && bus.i_ioaddr == ADDR_DATA && m_q.size() != 0) void'(m_q.pop_front());
    if (bus.i_rda && !m_busy) begin
      if (m_q.size() < DEPTH) m_q.push_back(bus.i_rx_data);
      else set_ovr = 1'b1;
    end
    if (rise && bus.i_ioaddr == ADDR_STATUS) m_ovr = 1'b0;
    if (set_ovr) m_ovr = 1'b1;
    m_busy     = bus.i_rda;
    m_strobe_q = strobe;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.i_ioaddr = ADDR_STATUS;
    bus.i_iocs   = 1'b0;
    rst = 1'b0;
    m_q.delete();
    m_ovr = 1'b0; m_busy = 1'b0; m_strobe_q = 1'b0;
    #1;
    chk("rst_status", bus.o_rdata, 8'h10);
    chk("rst_rda", {7'd0, bus.o_rda}, 8'h00);
    chk("rst_ack", {7'd0, bus.o_rx_ack}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rx_byte(input logic [7:0] d, input int hold);
    bus.i_rda = 1'b1; bus.i_rx_data = d;
    for (int i = 0; i < hold; i++) begin
      tick();
      #1 chk("rx_ack_high", {7'd0, bus.o_rx_ack}, 8'h01);
    end
    bus.i_rda = 1'b0;
    tick();
    #1 chk("rx_ack_low", {7'd0, bus.o_rx_ack}, 8'h00);
  endtask

  // Strobed read: check data while strobe is high, then release.
  task automatic cpu_read(input string tag, input logic [1:0] a, input logic [7:0] lit);
    bus.i_iocs = 1'b1; bus.i_iorw = 1'b1; bus.i_ioaddr = a;
    #1;
    chk({tag, "_model"}, bus.o_rdata, exp_rdata(a));
    chk({tag, "_lit"}, bus.o_rdata, lit);
    tick();
    bus.i_iocs = 1'b0;
    tick();
  endtask

  task automatic peek(input string tag, input logic [1:0] a, input logic [7:0] lit);
    bus.i_iocs = 1'b0; bus.i_ioaddr = a;
    #1;
    chk({tag, "_model"}, bus.o_rdata, exp_rdata(a));
    chk({tag, "_lit"}, bus.o_rdata, lit);
  endtask

  initial begin
    logic [7:0] first;
    logic [7:0] b;
    bus.i_rda = 1'b0; bus.i_rx_data = 8'h00;
    bus.i_iocs = 1'b0; bus.i_iorw = 1'b0; bus.i_ioaddr = 2'b00;
    @(negedge clk);

    // Reset state
    do_reset();
    check_outputs("post_reset");

    // Single byte, held five cycles
    rx_byte(8'hA5, 5);
    cpu_read("single_status", ADDR_STATUS, 8'h01);
    cpu_read("single_data", ADDR_DATA, 8'hA5);
    peek("single_after", ADDR_STATUS, 8'h10);

    // Ordering and pointer wrap: 12 bytes, drain after every fourth
    for (int i = 1; i <= 12; i++) begin
      rx_byte(8'(i), 1 + (i % 3));
      #1 chk("wrap_level_le8", {7'd0, (exp_status() <= 8'h08 || bus.o_rdata[3:0] <= 4'd8)}, 8'h01);
      if (i % 4 == 0)
        for (int k = i - 3; k <= i; k++) cpu_read("wrap_data", ADDR_DATA, 8'(k));
    end
    peek("wrap_empty", ADDR_STATUS, 8'h10);

    // Overrun: nine bytes, no reads
    first = 8'($urandom);
    rx_byte(first, 1);
    for (int i = 0; i < 8; i++) rx_byte(8'($urandom), 1 + $urandom_range(0, 2));
    peek("ovr_status", ADDR_STATUS, 8'hA8);
    peek("ovr_head", ADDR_DATA, first);
    cpu_read("ovr_read1", ADDR_STATUS, 8'hA8);
    cpu_read("ovr_read2", ADDR_STATUS, 8'h28);

    // Full: push coincides with pop strobe edge
    b = 8'($urandom);
    bus.i_rda = 1'b1; bus.i_rx_data = b;
    bus.i_iocs = 1'b1; bus.i_iorw = 1'b1; bus.i_ioaddr = ADDR_DATA;
    tick();
    bus.i_rda = 1'b0; bus.i_iocs = 1'b0;
    tick();
    peek("simul_pop_push", ADDR_STATUS, 8'h28);

    // Overrun set coincides with status read: set wins
    bus.i_rda = 1'b1; bus.i_rx_data = 8'($urandom);
    bus.i_iocs = 1'b1; bus.i_iorw = 1'b1; bus.i_ioaddr = ADDR_STATUS;
    tick();
    bus.i_rda = 1'b0; bus.i_iocs = 1'b0;
    tick();
    peek("simul_set_clr", ADDR_STATUS, 8'hA8);

    // Held strobe pops once; empty read returns zero
    do_reset();
    for (int i = 0; i < 3; i++) rx_byte(8'($urandom), 1);
    bus.i_iocs = 1'b1; bus.i_iorw = 1'b1; bus.i_ioaddr = ADDR_DATA;
    for (int i = 0; i < 4; i++) tick();
    bus.i_iocs = 1'b0;
    tick();
    peek("held_strobe", ADDR_STATUS, 8'h02);
    cpu_read("drain1", ADDR_DATA, m_q[0]);
    cpu_read("drain2", ADDR_DATA, m_q[0]);
    cpu_read("empty_read", ADDR_DATA, 8'h00);
    peek("empty_status", ADDR_STATUS, 8'h10);

    // Reset mid-handshake, i_rda stays high through release
    bus.i_rda = 1'b1; bus.i_rx_data = 8'h5A;
    tick();
    #1 chk("mid_ack_pre", {7'd0, bus.o_rx_ack}, 8'h01);
    #2;
    do_reset();
    bus.i_rda = 1'b1;
    tick();
    #1 chk("mid_recapture_ack", {7'd0, bus.o_rx_ack}, 8'h01);
    bus.i_rda = 1'b0;
    tick();
    peek("mid_level", ADDR_STATUS, 8'h01);
    peek("mid_data", ADDR_DATA, 8'h5A);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.i_rda     = 1'($urandom_range(0, 1));
      bus.i_rx_data = 8'($urandom);
      bus.i_iocs    = 1'($urandom_range(0, 1));
      bus.i_iorw    = 1'($urandom_range(0, 1));
      bus.i_ioaddr  = 2'($urandom_range(0, 3));
      check_outputs("rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
